// File: rtl/mctrl_pkg.sv
// Shared types for the Schwap multicycle controller: state codes, opcode
// classes and datapath mux encodings.
package mctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  localparam logic [3:0] OP_ALU    = 4'd0;
  localparam logic [3:0] OP_ALUI   = 4'd1;
  localparam logic [3:0] OP_BR_LO  = 4'd2;
  localparam logic [3:0] OP_BR_HI  = 4'd5;
  localparam logic [3:0] OP_JR     = 4'd6;
  localparam logic [3:0] OP_LD     = 4'd7;
  localparam logic [3:0] OP_ST     = 4'd8;
  localparam logic [3:0] OP_SCHWAP = 4'd14;
  localparam logic [3:0] OP_HALT   = 4'd15;

  localparam logic [1:0] A0_PC  = 2'b00;
  localparam logic [1:0] A0_REG = 2'b01;
  localparam logic [1:0] A0_OFS = 2'b10;

  localparam logic [1:0] RS_ALU = 2'b00;
  localparam logic [1:0] RS_IMM = 2'b01;
  localparam logic [1:0] RS_MEM = 2'b10;

  typedef struct packed {
    logic alu;
    logic alui;
    logic br;
    logic jr;
    logic ld;
    logic st;
    logic schwap;
    logic halt;
  } opclass_t;

endpackage

// File: rtl/mctrl_decode.sv
// Opcode classifier: maps the latched opcode to a class one-hot and a legal
// flag. Any opcode with bits set above bit 3 is illegal.
module mctrl_decode
  import mctrl_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic [OPW-1:0] op,
  output opclass_t       cls,
  output logic           legal
);

  logic [3:0] low_s;
  logic       hi_zero_s;
  opclass_t   raw_s;

  assign low_s = op[3:0];

  if (OPW > 4) begin : g_wide
    assign hi_zero_s = ~|op[OPW-1:4];
  end else begin : g_narrow
    assign hi_zero_s = 1'b1;
  end

  // low nibble to class one-hot
  always_comb begin
    raw_s = 8'h00;
    case (low_s)
      OP_ALU:                 raw_s.alu    = 1'b1;
      OP_ALUI:                raw_s.alui   = 1'b1;
      4'd2, 4'd3, 4'd4, 4'd5: raw_s.br     = 1'b1;
      OP_JR:                  raw_s.jr     = 1'b1;
      OP_LD:                  raw_s.ld     = 1'b1;
      OP_ST:                  raw_s.st     = 1'b1;
      OP_SCHWAP:              raw_s.schwap = 1'b1;
      OP_HALT:                raw_s.halt   = 1'b1;
      default:                raw_s        = 8'h00;
    endcase
  end

  assign cls   = hi_zero_s ? raw_s : 8'h00;
  assign legal = |cls;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the Schwap datapath. Define MCTRL_MEMWAIT_EN to
// make FETCH and MEM wait for mem_ready; otherwise mem_ready is ignored.
module multicycle_ctrl
  import mctrl_pkg::*;
#(
  parameter int OPW           = 4,
  parameter int SCHWAP_CYCLES = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] opcode,
  input  logic           br_cond,
  input  logic           mem_ready,
  output logic           pc_src,
  output logic           pc_write,
  output logic           addr0_src,
  output logic           mem_read,
  output logic           mem_write,
  output logic           ir_write,
  output logic           next_inst_write,
  output logic           reg_write,
  output logic           imm,
  output logic           r0_write,
  output logic           r1_write,
  output logic           alu_src1,
  output logic           alu_ctrl,
  output logic           schwap_pulse,
  output logic [1:0]     reg_store,
  output logic [1:0]     alu_src0,
  output logic [2:0]     state_o,
  output logic           halted,
  output logic           illegal
);

  localparam logic [3:0] SCHW_LAST = 4'(SCHWAP_CYCLES - 1);

  state_e         state_r, state_nx_s;
  logic [OPW-1:0] op_q_r;
  logic [3:0]     cnt_r, cnt_nx_s;
  logic           halted_r, illegal_r;
  opclass_t       cls_s;
  logic           legal_s;
  logic           mem_ok_s;

`ifdef MCTRL_MEMWAIT_EN
  assign mem_ok_s = mem_ready;
`else
  logic unused_mem_ready_s;
  assign unused_mem_ready_s = mem_ready;
  assign mem_ok_s = 1'b1;
`endif

  mctrl_decode #(.OPW(OPW)) u_decode (
    .op    (op_q_r),
    .cls   (cls_s),
    .legal (legal_s)
  );

  // next state and SCHWAP hold counter
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    case (state_r)
      ST_IDLE:   state_nx_s = ST_FETCH;
      ST_FETCH:  state_nx_s = mem_ok_s ? ST_DECODE : ST_FETCH;
      ST_DECODE: state_nx_s = legal_s ? ST_EXEC : ST_FETCH;
      ST_EXEC: begin
        if (cls_s.alu || cls_s.alui) begin
          state_nx_s = ST_WB;
        end else if (cls_s.ld || cls_s.st) begin
          state_nx_s = ST_MEM;
        end else if (cls_s.schwap) begin
          if (cnt_r == SCHW_LAST) begin
            state_nx_s = ST_FETCH;
            cnt_nx_s   = 4'd0;
          end else begin
            state_nx_s = ST_EXEC;
            cnt_nx_s   = cnt_r + 4'd1;
          end
        end else if (cls_s.halt) begin
          state_nx_s = ST_HALT;
        end else begin
          state_nx_s = ST_FETCH;
        end
      end
      ST_MEM: begin
        if (!mem_ok_s) begin
          state_nx_s = ST_MEM;
        end else if (cls_s.ld) begin
          state_nx_s = ST_WB;
        end else begin
          state_nx_s = ST_FETCH;
        end
      end
      ST_WB:   state_nx_s = ST_FETCH;
      ST_HALT: state_nx_s = ST_HALT;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // state, latched opcode and sticky status registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      op_q_r    <= {OPW{1'b0}};
      cnt_r     <= 4'd0;
      halted_r  <= 1'b0;
      illegal_r <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      if (state_r == ST_FETCH && mem_ok_s) begin
        op_q_r <= opcode;
      end
      if (state_r == ST_DECODE && !legal_s) begin
        illegal_r <= 1'b1;
      end
      if (state_nx_s == ST_HALT) begin
        halted_r <= 1'b1;
      end
    end
  end

  // Moore decode of state and class; br_cond and mem_ready are the only live inputs
  always_comb begin
    pc_src          = 1'b0;
    pc_write        = 1'b0;
    addr0_src       = 1'b0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    ir_write        = 1'b0;
    next_inst_write = 1'b0;
    reg_write       = 1'b0;
    imm             = 1'b0;
    r0_write        = 1'b0;
    r1_write        = 1'b0;
    alu_src1        = 1'b0;
    alu_ctrl        = 1'b0;
    schwap_pulse    = 1'b0;
    reg_store       = RS_ALU;
    alu_src0        = A0_PC;
    case (state_r)
      ST_FETCH: begin
        pc_src          = 1'b1;
        pc_write        = mem_ok_s;
        addr0_src       = 1'b1;
        mem_read        = 1'b1;
        ir_write        = 1'b1;
        next_inst_write = 1'b1;
      end
      ST_DECODE: begin
        r0_write  = legal_s;
        r1_write  = legal_s;
        alu_src1  = 1'b1;
        alu_src0  = A0_PC;
        pc_write  = cls_s.alui;
        imm       = cls_s.alui;
        reg_store = cls_s.alui ? RS_IMM : RS_ALU;
      end
      ST_EXEC: begin
        if (cls_s.alu || cls_s.alui) begin
          alu_src0 = A0_REG;
          alu_ctrl = 1'b1;
        end else if (cls_s.br) begin
          alu_src0 = A0_OFS;
          pc_write = br_cond;
        end else if (cls_s.jr) begin
          alu_src0 = A0_REG;
          alu_src1 = 1'b1;
          pc_write = 1'b1;
        end else if (cls_s.ld || cls_s.st) begin
          alu_src0 = A0_OFS;
        end else if (cls_s.schwap) begin
          schwap_pulse = 1'b1;
        end else begin
          alu_src0 = A0_PC;
        end
      end
      ST_MEM: begin
        addr0_src = 1'b0;
        mem_read  = cls_s.ld;
        mem_write = cls_s.st;
      end
      ST_WB: begin
        reg_write = 1'b1;
        reg_store = cls_s.ld ? RS_MEM : RS_ALU;
      end
      default: begin
        pc_src = 1'b0;
      end
    endcase
  end

  assign state_o = state_r;
  assign halted  = halted_r;
  assign illegal = illegal_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: each instruction is expanded into its
// expected per-cycle output trace, which is driven and compared cycle by cycle.
module tb_multicycle_ctrl;

`ifdef MCTRL_MEMWAIT_EN
  localparam bit MEMWAIT = 1'b1;
`else
  localparam bit MEMWAIT = 1'b0;
`endif
  localparam int SCHW_N = 3;

  localparam int C_ALU = 0, C_ALUI = 1, C_BR = 2, C_JR = 3, C_LD = 4,
                 C_ST = 5, C_SCHWAP = 6, C_HALT = 7, C_ILL = 8;

  typedef struct packed {
    logic [2:0] st;
    logic halted, illegal, pc_src, pc_write, addr0_src, mem_read, mem_write;
    logic ir_write, nxt, reg_write, imm, r0w, r1w, alu_src1, alu_ctrl, schwap;
    logic [1:0] reg_store, alu_src0;
  } outs_t;

  typedef struct packed {
    outs_t      o;
    logic [3:0] opc;
    logic       br;
    logic       mr;
  } entry_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] opcode = 4'd0;
  logic br_cond = 1'b0, mem_ready = 1'b0;
  logic pc_src, pc_write, addr0_src, mem_read, mem_write, ir_write, next_inst_write;
  logic reg_write, imm, r0_write, r1_write, alu_src1, alu_ctrl, schwap_pulse;
  logic [1:0] reg_store, alu_src0;
  logic [2:0] state_o;
  logic halted, illegal;

  outs_t  act, exp_cur;
  logic   exp_valid = 1'b0;
  entry_t q[$];
  int     pushed = 0, cyc = 0;
  int     total = 0, bad = 0;
  logic   ill_m = 1'b0;

  multicycle_ctrl #(.OPW(4), .SCHWAP_CYCLES(SCHW_N)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .br_cond(br_cond), .mem_ready(mem_ready),
    .pc_src(pc_src), .pc_write(pc_write), .addr0_src(addr0_src), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .next_inst_write(next_inst_write),
    .reg_write(reg_write), .imm(imm), .r0_write(r0_write), .r1_write(r1_write),
    .alu_src1(alu_src1), .alu_ctrl(alu_ctrl), .schwap_pulse(schwap_pulse),
    .reg_store(reg_store), .alu_src0(alu_src0), .state_o(state_o),
    .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign act = {state_o, halted, illegal, pc_src, pc_write, addr0_src, mem_read, mem_write,
                ir_write, next_inst_write, reg_write, imm, r0_write, r1_write, alu_src1,
                alu_ctrl, schwap_pulse, reg_store, alu_src0};

  // per-cycle comparison against the expanded trace
  always @(negedge clk) begin
    #2;
    if (exp_valid) begin
      total++;
      if (act !== exp_cur) begin
        bad++;
        $display("FAIL outs cyc=%0d state got=%0d want=%0d vec got=%h want=%h",
                 cyc, act.st, exp_cur.st, act, exp_cur);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, a, e);
    end
  endtask

  function automatic int cls_of(input logic [3:0] op);
    if (op == 4'd0) return C_ALU;
    if (op == 4'd1) return C_ALUI;
    if (op >= 4'd2 && op <= 4'd5) return C_BR;
    if (op == 4'd6) return C_JR;
    if (op == 4'd7) return C_LD;
    if (op == 4'd8) return C_ST;
    if (op == 4'd14) return C_SCHWAP;
    if (op == 4'd15) return C_HALT;
    return C_ILL;
  endfunction

  function automatic outs_t base(input logic [2:0] st);
    outs_t o;
    o = '0;
    o.st = st;
    o.illegal = ill_m;
    return o;
  endfunction

  task automatic push(input outs_t o, input logic [3:0] opc, input logic br, input logic mr);
    entry_t e;
    e.o = o; e.opc = opc; e.br = br; e.mr = mr;
    q.push_back(e);
    pushed++;
  endtask

  // expected trace of one instruction; opcode and br_cond are scrambled outside FETCH/EXEC
  task automatic add_instr(input logic [3:0] op, input logic br, input int fw, input int mw,
                           input bit stop_at_mem, output int n);
    outs_t o;
    int k, nf, nm, start;
    start = pushed;
    k  = cls_of(op);
    nf = MEMWAIT ? fw : 0;
    nm = MEMWAIT ? mw : 0;
    for (int i = 0; i <= nf; i++) begin
      o = base(3'd1);
      o.pc_src = 1'b1; o.pc_write = (i == nf); o.addr0_src = 1'b1;
      o.mem_read = 1'b1; o.ir_write = 1'b1; o.nxt = 1'b1;
      push(o, op, ~br, MEMWAIT ? (i == nf) : 1'b0);
    end
    o = base(3'd2);
    o.alu_src1 = 1'b1;
    o.r0w = (k != C_ILL); o.r1w = (k != C_ILL);
    if (k == C_ALUI) begin o.pc_write = 1'b1; o.reg_store = 2'b01; o.imm = 1'b1; end
    push(o, ~op, ~br, 1'b0);
    if (k == C_ILL) begin
      ill_m = 1'b1;
    end else if (k == C_SCHWAP) begin
      for (int i = 0; i < SCHW_N; i++) begin
        o = base(3'd3); o.schwap = 1'b1; push(o, ~op, br, 1'b0);
      end
    end else begin
      o = base(3'd3);
      case (k)
        C_ALU, C_ALUI: begin o.alu_src0 = 2'b01; o.alu_ctrl = 1'b1; end
        C_BR:          begin o.alu_src0 = 2'b10; o.pc_write = br; end
        C_JR:          begin o.alu_src0 = 2'b01; o.alu_src1 = 1'b1; o.pc_write = 1'b1; end
        C_LD, C_ST:    o.alu_src0 = 2'b10;
        default:       o.alu_src0 = 2'b00;
      endcase
      push(o, ~op, br, 1'b0);
      if ((k == C_LD || k == C_ST) && !stop_at_mem) begin
        for (int i = 0; i <= nm; i++) begin
          o = base(3'd4);
          o.mem_read = (k == C_LD); o.mem_write = (k == C_ST);
          push(o, ~op, ~br, MEMWAIT ? (i == nm) : 1'b0);
        end
      end
      if (k == C_ALU || k == C_ALUI || k == C_LD) begin
        o = base(3'd5); o.reg_write = 1'b1;
        o.reg_store = (k == C_LD) ? 2'b10 : 2'b00;
        push(o, ~op, ~br, 1'b0);
      end
    end
    n = pushed - start;
  endtask

  task automatic add_halt(input int cycles);
    outs_t o;
    for (int i = 0; i < cycles; i++) begin
      o = base(3'd6); o.halted = 1'b1; push(o, 4'h0, 1'b0, 1'b1);
    end
  endtask

  task automatic add_idle();
    push(base(3'd0), 4'h0, 1'b0, 1'b0);
  endtask

  // drive queued entries, one per cycle, starting at a falling edge
  task automatic drain();
    entry_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      opcode = e.opc; br_cond = e.br; mem_ready = e.mr;
      exp_cur = e.o; exp_valid = 1'b1;
      @(negedge clk);
      cyc++;
    end
    exp_valid = 1'b0;
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    #2;
    chk("reset_outs", 32'(act), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    add_idle();
    add_instr(4'd0, 1'b0, 0, 0, 1'b0, n);  chk("len_alu", n, 32'd4);
    add_instr(4'd1, 1'b1, 1, 0, 1'b0, n);  chk("len_alui", n, MEMWAIT ? 32'd5 : 32'd4);
    add_instr(4'd3, 1'b0, 0, 0, 1'b0, n);  chk("len_br0", n, 32'd3);
    add_instr(4'd3, 1'b1, 0, 0, 1'b0, n);  chk("len_br1", n, 32'd3);
    add_instr(4'd6, 1'b0, 0, 0, 1'b0, n);  chk("len_jr", n, 32'd3);
    add_instr(4'd7, 1'b1, 0, 3, 1'b0, n);  chk("len_ld", n, MEMWAIT ? 32'd8 : 32'd5);
    add_instr(4'd8, 1'b0, 2, 1, 1'b0, n);  chk("len_st", n, MEMWAIT ? 32'd7 : 32'd4);
    add_instr(4'd14, 1'b1, 0, 0, 1'b0, n); chk("len_schwap", n, 32'd5);
    add_instr(4'd10, 1'b0, 0, 0, 1'b0, n); chk("len_illegal", n, 32'd2);
    add_instr(4'd0, 1'b1, 0, 0, 1'b0, n);
    drain();
    #2;
    chk("illegal_sticky", 32'(illegal), 32'd1);

    add_instr(4'd8, 1'b0, 0, 0, 1'b1, n);
    drain();
    opcode = 4'h3; mem_ready = 1'b0;
    #2;
    chk("st_mem_state", 32'(state_o), 32'd4);
    chk("st_mem_write", 32'(mem_write), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_mem_write", 32'(mem_write), 32'd0);
    chk("abort_state", 32'(state_o), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    ill_m = 1'b0;
    add_idle();
    add_instr(4'd0, 1'b0, 0, 0, 1'b0, n);
    add_instr(4'd10, 1'b1, 0, 0, 1'b0, n);
    add_instr(4'd15, 1'b0, 0, 0, 1'b0, n);
    add_halt(20);
    drain();
    #2;
    chk("halted_end", 32'(halted), 32'd1);
    chk("halt_state_end", 32'(state_o), 32'd6);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
